// File: rtl/abs_diff_pkg.sv
// Shared types and helpers for the approximate absolute-difference pipeline.
// Functions operate on MAX_W-bit values; callers zero-extend and slice back to their width.
package abs_diff_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_EXACT   = 2'd0,
        MODE_TRUNC   = 2'd1,
        MODE_BOUNDED = 2'd2
    } mode_e;

    function automatic logic [MAX_W-1:0] abs_diff(input logic [MAX_W-1:0] x,
                                                  input logic [MAX_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    // Ones everywhere except the n low bits, which approximate modes drop.
    function automatic logic [MAX_W-1:0] trunc_mask(input int n);
        return ~((MAX_W'(1) << n) - MAX_W'(1));
    endfunction

endpackage

// File: rtl/abs_diff_approx_pipe_if.sv
// Operand/result stream bundle: valid/ready on both the operand and the result side.
interface abs_diff_approx_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] err;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, diff, err
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, diff, err
    );
endinterface

// File: rtl/abs_diff_err_stats.sv
// Running error statistics over accepted results: sample count, max error, violations.
// Clear takes priority over a same-cycle transfer, which is then not counted.
module abs_diff_err_stats #(
    parameter int WIDTH = 4,
    parameter int ET    = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_i,
    input  logic [WIDTH-1:0] err_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [WIDTH-1:0] max_err_o,
    output logic [CNT_W-1:0] viol_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ET_W    = WIDTH'(ET);

    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] viol_q, viol_d;
    logic [WIDTH-1:0] max_q, max_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        sample_d = sample_q;
        viol_d   = viol_q;
        max_d    = max_q;
        if (hs_i) begin
            sample_d = sat_inc(sample_q);
            if (err_i > max_q) max_d = err_i;
            if (err_i > ET_W)  viol_d = sat_inc(viol_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            sample_q <= '0;
            viol_q   <= '0;
            max_q    <= '0;
        end else begin
            sample_q <= sample_d;
            viol_q   <= viol_d;
            max_q    <= max_d;
        end
    end

    assign sample_cnt_o = sample_q;
    assign viol_cnt_o   = viol_q;
    assign max_err_o    = max_q;

endmodule

// File: rtl/abs_diff_approx_pipe.sv
// Two-stage |a-b| pipeline with exact, truncated and error-bounded output modes,
// plus in-system error statistics on the result handshake.
module abs_diff_approx_pipe
    import abs_diff_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TRUNC_BITS = 2,
    parameter int ET         = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    abs_diff_approx_pipe_if.slave bus,
    input  logic                  clear_stats,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic [WIDTH-1:0]      max_err,
    output logic [CNT_W-1:0]      viol_cnt
);

    localparam logic [MAX_W-1:0] MASK_FULL = trunc_mask(TRUNC_BITS);
    localparam logic [WIDTH-1:0] MASK      = MASK_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ET_W      = WIDTH'(ET);

    logic             s1_vld_q, s2_vld_q;
    logic [WIDTH-1:0] exact_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [MAX_W-1:0] exact_full;
    logic [WIDTH-1:0] exact_d, trunc_v, trunc_e;
    logic             s1_adv, in_fire, out_fire;

    assign s1_adv       = !s2_vld_q || bus.out_ready;
    assign bus.in_ready = !s1_vld_q || s1_adv;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = s2_vld_q && bus.out_ready;

    // Stage 1: exact absolute difference, captured with the mode at the handshake
    assign exact_full = abs_diff(MAX_W'(bus.a), MAX_W'(bus.b));
    assign exact_d    = exact_full[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (in_fire) begin
            exact_q <= exact_d;
            mode_q  <= bus.mode;
        end
    end

    // Stage 2: apply the approximation selected for this operand pair
    always_comb begin
        trunc_v = exact_q & MASK;
        trunc_e = exact_q - trunc_v;
        diff_d  = exact_q;
        err_d   = '0;
        case (mode_q)
            MODE_TRUNC: begin
                diff_d = trunc_v;
                err_d  = trunc_e;
            end
            MODE_BOUNDED: begin
                if (trunc_e <= ET_W) begin
                    diff_d = trunc_v;
                    err_d  = trunc_e;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            diff_q   <= '0;
            err_q    <= '0;
        end else begin
            if (bus.in_ready) s1_vld_q <= bus.in_valid;
            if (s1_adv)       s2_vld_q <= s1_vld_q;
            if (s1_adv && s1_vld_q) begin
                diff_q <= diff_d;
                err_q  <= err_d;
            end
        end
    end

    assign bus.out_valid = s2_vld_q;
    assign bus.diff      = diff_q;
    assign bus.err       = err_q;

    abs_diff_err_stats #(
        .WIDTH (WIDTH),
        .ET    (ET),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .hs_i         (out_fire),
        .err_i        (err_q),
        .clear_i      (clear_stats),
        .sample_cnt_o (sample_cnt),
        .max_err_o    (max_err),
        .viol_cnt_o   (viol_cnt)
    );

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// Directed bench for abs_diff_approx_pipe: default-parameter unit plus a CNT_W=3 unit.
module tb_abs_diff_approx_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear1 = 1'b0;
    logic clear2 = 1'b0;

    logic [15:0] sample1, viol1;
    logic [3:0]  maxerr1;
    logic [2:0]  sample2, viol2;
    logic [3:0]  maxerr2;

    int tests = 0;
    int fails = 0;
    int in_idx = 0;
    int out_idx = 0;
    bit dropped = 1'b0;

    logic [3:0] sa [8] = '{4'd15, 4'd0,  4'd7, 4'd3, 4'd10, 4'd1, 4'd8, 4'd12};
    logic [3:0] sb [8] = '{4'd0,  4'd15, 4'd3, 4'd9, 4'd10, 4'd0, 4'd1, 4'd6};
    logic [3:0] sd [8] = '{4'd12, 4'd12, 4'd4, 4'd4, 4'd0,  4'd0, 4'd4, 4'd4};
    logic [3:0] se [8] = '{4'd3,  4'd3,  4'd0, 4'd2, 4'd0,  4'd1, 4'd3, 4'd2};

    abs_diff_approx_pipe_if #(.WIDTH(4)) bus1 ();
    abs_diff_approx_pipe_if #(.WIDTH(4)) bus2 ();

    abs_diff_approx_pipe #(.WIDTH(4), .TRUNC_BITS(2), .ET(2), .CNT_W(16)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus1.slave),
        .clear_stats (clear1),
        .sample_cnt  (sample1),
        .max_err     (maxerr1),
        .viol_cnt    (viol1)
    );

    abs_diff_approx_pipe #(.WIDTH(4), .TRUNC_BITS(2), .ET(2), .CNT_W(3)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus2.slave),
        .clear_stats (clear2),
        .sample_cnt  (sample2),
        .max_err     (maxerr2),
        .viol_cnt    (viol2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_one(input string tag, input logic [3:0] av, input logic [3:0] bv,
                          input logic [1:0] m, input logic [3:0] ed, input logic [3:0] ee);
        bus1.a = av;
        bus1.b = bv;
        bus1.mode = m;
        bus1.out_ready = 1'b1;
        bus1.in_valid = 1'b1;
        tick;
        bus1.in_valid = 1'b0;
        tick;
        chk({tag, "_vld"}, 32'(bus1.out_valid), 32'd1);
        chk({tag, "_diff"}, 32'(bus1.diff), 32'(ed));
        chk({tag, "_err"}, 32'(bus1.err), 32'(ee));
        tick;
    endtask

    initial begin
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.mode = 2'd0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.mode = 2'd0; bus2.out_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
        chk("rst_diff", 32'(bus1.diff), 32'd0);
        chk("rst_err", 32'(bus1.err), 32'd0);
        chk("rst_sample", 32'(sample1), 32'd0);
        chk("rst_max", 32'(maxerr1), 32'd0);
        chk("rst_viol", 32'(viol1), 32'd0);

        do_one("m0_13_2", 4'd13, 4'd2, 2'd0, 4'd11, 4'd0);
        do_one("m0_2_13", 4'd2, 4'd13, 2'd0, 4'd11, 4'd0);
        do_one("m0_5_5", 4'd5, 4'd5, 2'd0, 4'd0, 4'd0);
        do_one("m3_7_1", 4'd7, 4'd1, 2'd3, 4'd6, 4'd0);
        chk("m0_sample", 32'(sample1), 32'd4);
        chk("m0_viol", 32'(viol1), 32'd0);

        do_one("m1_13_2", 4'd13, 4'd2, 2'd1, 4'd8, 4'd3);
        chk("m1a_viol", 32'(viol1), 32'd1);
        chk("m1a_max", 32'(maxerr1), 32'd3);
        do_one("m1_9_4", 4'd9, 4'd4, 2'd1, 4'd4, 4'd1);
        chk("m1b_viol", 32'(viol1), 32'd1);
        chk("m1b_max", 32'(maxerr1), 32'd3);

        do_one("m2_13_2", 4'd13, 4'd2, 2'd2, 4'd11, 4'd0);
        do_one("m2_14_4", 4'd14, 4'd4, 2'd2, 4'd8, 4'd2);
        chk("m2_viol", 32'(viol1), 32'd1);
        chk("m2_sample", 32'(sample1), 32'd8);

        // clear coinciding with an output handshake
        bus1.a = 4'd13; bus1.b = 4'd2; bus1.mode = 2'd1; bus1.in_valid = 1'b1;
        tick;
        bus1.in_valid = 1'b0;
        tick;
        chk("clr_vld_before", 32'(bus1.out_valid), 32'd1);
        clear1 = 1'b1;
        tick;
        clear1 = 1'b0;
        chk("clr_sample", 32'(sample1), 32'd0);
        chk("clr_viol", 32'(viol1), 32'd0);
        chk("clr_max", 32'(maxerr1), 32'd0);
        chk("clr_drained", 32'(bus1.out_valid), 32'd0);
        do_one("post_clr", 4'd3, 4'd1, 2'd0, 4'd2, 4'd0);
        chk("post_clr_sample", 32'(sample1), 32'd1);

        clear1 = 1'b1;
        tick;
        clear1 = 1'b0;
        chk("clr2_sample", 32'(sample1), 32'd0);

        // back-to-back stream with the consumer stalled for the first three cycles
        bus1.mode = 2'd1;
        for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
            bus1.in_valid = (in_idx < 8);
            if (in_idx < 8) begin
                bus1.a = sa[in_idx];
                bus1.b = sb[in_idx];
            end
            bus1.out_ready = (cyc >= 3);
            #2;
            if (!bus1.in_ready && !dropped) begin
                dropped = 1'b1;
                chk("stream_in_ready_drop", 32'(in_idx), 32'd2);
            end
            if (bus1.out_valid) begin
                chk("stream_diff", 32'(bus1.diff), 32'(sd[out_idx]));
                chk("stream_err", 32'(bus1.err), 32'(se[out_idx]));
            end
            if (bus1.in_valid && bus1.in_ready) in_idx++;
            if (bus1.out_valid && bus1.out_ready) out_idx++;
            tick;
        end
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        chk("stream_out_count", 32'(out_idx), 32'd8);
        chk("stream_in_count", 32'(in_idx), 32'd8);
        chk("stream_dropped", 32'(dropped), 32'd1);
        chk("stream_empty", 32'(bus1.out_valid), 32'd0);
        chk("stream_sample", 32'(sample1), 32'd8);
        chk("stream_viol", 32'(viol1), 32'd3);
        chk("stream_max", 32'(maxerr1), 32'd3);

        // saturation on the narrow-counter unit
        bus2.mode = 2'd1; bus2.a = 4'd13; bus2.b = 4'd2; bus2.out_ready = 1'b1;
        bus2.in_valid = 1'b1;
        repeat (10) tick;
        bus2.in_valid = 1'b0;
        repeat (3) tick;
        chk("sat_sample", 32'(sample2), 32'd7);
        chk("sat_viol", 32'(viol2), 32'd7);
        chk("sat_max", 32'(maxerr2), 32'd3);

        // reset with both pipelines full
        bus2.in_valid = 1'b1;
        bus1.in_valid = 1'b1; bus1.a = 4'd9; bus1.b = 4'd0;
        repeat (3) tick;
        chk("mid_vld_before", 32'(bus2.out_valid), 32'd1);
        rst = 1'b1;
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        tick;
        chk("mid_rst_vld2", 32'(bus2.out_valid), 32'd0);
        chk("mid_rst_sample2", 32'(sample2), 32'd0);
        chk("mid_rst_viol2", 32'(viol2), 32'd0);
        chk("mid_rst_max2", 32'(maxerr2), 32'd0);
        chk("mid_rst_diff2", 32'(bus2.diff), 32'd0);
        chk("mid_rst_vld1", 32'(bus1.out_valid), 32'd0);
        chk("mid_rst_sample1", 32'(sample1), 32'd0);
        rst = 1'b0;
        tick;
        tick;
        chk("post_rst_vld2", 32'(bus2.out_valid), 32'd0);
        chk("post_rst_sample2", 32'(sample2), 32'd0);
        chk("post_rst_in_ready2", 32'(bus2.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
